uart_echo_bridge: RTL and testbench
===================================

Name: uart_echo_bridge

Overview:
Parametrised successor to the receiver-to-transmitter coupling block in the UART loopback path. It sits between the UART receiver and the UART transmitter. Received words are buffered in a DEPTH-entry FIFO instead of being forwarded one at a time. A transmit state machine drains the FIFO into the transmitter with a start/done handshake. Backpressure goes to the receiver through rx_enable, and a sticky overflow flag reports dropped words.

Parameters:
DATA_W, 8, word width of received/transmitted data
DEPTH, 16, FIFO entries; power of two, >= 2; AW = log2(DEPTH) is derived internally

Ports:
clc  in  1  system clock, all logic on rising edge
res  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_data holds a complete received word
rx_data  in  DATA_W  word from receiver
rx_enable  out  1  receiver enable; 1 = FIFO can accept a word
tx_start  out  1  level; 1 = tx_data valid, transmitter must send it
tx_data  out  DATA_W  word to transmitter; held stable while tx_start=1
tx_done  in  1  one-cycle pulse from transmitter: current word finished
fill_count  out  AW+1  number of words currently stored
overflow  out  1  sticky: a word arrived while FIFO was full
clr_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset (res=0, asynchronous):
  - Outputs: rx_enable=1, tx_start=0, tx_data=0, fill_count=0, overflow=0.
  - Internal: read/write pointers=0, FSM=IDLE. FIFO memory is not reset.
- Reset mid-operation: the current word and all buffered words are discarded.
- rx_enable = (fill_count != DEPTH). It is decoded from the registered count only; there is no combinational path from any input.
- Push, edge with rx_valid=1:
  - If fill_count<DEPTH: write rx_data at the write pointer; pointer increments modulo DEPTH.
  - If fill_count==DEPTH: word dropped; overflow=1 from the next cycle.
  - A pop on the same edge does not make room for this push. Fullness is judged on the pre-edge count.
- Pop: performed only by the FSM, as described below.
- Same-edge push+pop: fill_count unchanged.
- Pointer wrap: both pointers wrap DEPTH-1 -> 0 with no gap. fill_count is a separate AW+1-bit counter, so full and empty are never ambiguous.
- Overflow flag: clr_overflow=1 clears it on the edge. If a new overflow event occurs on the same edge, set wins (overflow=1).
- Transmit FSM states IDLE, BUSY, GAP:
  - IDLE: if fill_count>0, latch head word into tx_data, pop, set tx_start=1, go to BUSY. tx_done is ignored.
  - BUSY: tx_start=1, tx_data frozen. On tx_done=1: tx_start=0, go to GAP. rx_valid/push continue normally.
  - GAP: one cycle with tx_start=0 so the transmitter sees a low level. Go to IDLE; tx_done is ignored.
- Latency: rx_valid sampled at edge k into an empty FIFO with FSM in IDLE -> word written at edge k. tx_start=1 and tx_data=word after edge k+1.
- Back-to-back throughput: after tx_done at edge m, tx_start is low after edge m (GAP). The next word is presented with tx_start=1 after edge m+2 if the FIFO is non-empty.
- Ordering: strict FIFO; words are transmitted in arrival order, with no duplication or loss except overflow drops.

Test Plan:
1. Reset, then single rx_valid with rx_data=0x41 at edge k -> fill_count=1 after k, tx_start=1 with tx_data=0x41 after k+1, fill_count=0 after k+1. tx_done at edge m -> tx_start=0 after m.
2. DEPTH=16: push 0x00..0x0F while holding tx_done low (first word in BUSY) -> FIFO refills to count 15, transmit order 0x00,0x01,... preserved as tx_done is pulsed each time. A further burst reaching fill_count=16 -> rx_enable=0, overflow stays 0.
3. FIFO full (16) and rx_valid with 0xAA -> word dropped, overflow=1, fill_count=16. Then pulse clr_overflow -> overflow=0. Then clr_overflow on the same edge as another drop -> overflow=1.
4. Push 40 words with continuous tx_done pulses -> pointers wrap twice, output sequence equals input sequence, no overflow.
5. With fill_count=16, FSM pops in IDLE on the same edge as rx_valid=0x55 -> 0x55 dropped, overflow=1, fill_count=15.
6. Assert res low while in BUSY with 5 words buffered -> next cycle tx_start=0, fill_count=0, rx_enable=1. Release res -> no transmission until a new rx_valid arrives.

Source files
------------

// File: rtl/uart_echo_bridge_if.sv
// Receiver/transmitter-side signal bundle of the UART echo bridge.
// The bridge sits on the slave modport; the surrounding receiver/transmitter environment uses the master modport.
interface uart_echo_bridge_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int AW = $clog2(DEPTH);

  // Receive side: a word moves only on a cycle with rx_valid=1; rx_enable=1 means it will be stored.
  // A word offered while rx_enable=0 is dropped and flagged in overflow.
  // Transmit side: tx_start is a level, and tx_data is stable while it is high.
  // A one-cycle tx_done pulse completes the word, and tx_start then drops for at least one cycle.
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_enable;
  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done;
  logic [AW:0]       fill_count;
  logic              overflow;
  logic              clr_overflow;
  logic [1:0]        fsm_state;

  modport slave (
    input  rx_valid, rx_data, tx_done, clr_overflow,
    output rx_enable, tx_start, tx_data, fill_count, overflow, fsm_state
  );

  modport master (
    output rx_valid, rx_data, tx_done, clr_overflow,
    input  rx_enable, tx_start, tx_data, fill_count, overflow, fsm_state
  );
endinterface

// File: rtl/uart_echo_bridge.sv
// Buffers received UART words in a FIFO and drains them into the transmitter
// through a start/done handshake; drops on a full FIFO raise a sticky overflow flag.
module uart_echo_bridge #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                clc,
  input  logic                res,
  uart_echo_bridge_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       cnt;
  logic [DATA_W-1:0] tx_data_q;
  logic              ovf_q;
  logic              full;
  logic              push;
  logic              drop;
  logic              pop;

  // Fullness comes from the registered count only, so a pop on the same edge never frees room.
  assign full = (cnt == FULL_CNT);
  assign push = bus.rx_valid && !full;
  assign drop = bus.rx_valid && full;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cnt != '0) begin
          pop     = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.tx_done) state_d = S_GAP;
      end
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clc or negedge res) begin
    if (!res) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clc) begin
    if (push) mem[wr_ptr] <= bus.rx_data;
  end

  always_ff @(posedge clc or negedge res) begin
    if (!res) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      tx_data_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        tx_data_q <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)                  ovf_q <= 1'b1;
      else if (bus.clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign bus.rx_enable  = !full;
  assign bus.tx_start   = (state_q == S_BUSY);
  assign bus.tx_data    = tx_data_q;
  assign bus.fill_count = cnt;
  assign bus.overflow   = ovf_q;
  assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_uart_echo_bridge.sv
// Randomised and directed bench for uart_echo_bridge against a queue-based reference model.
module tb_uart_echo_bridge;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk;
  logic rst_n;

  uart_echo_bridge_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_echo_bridge #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clc (clk),
    .res (rst_n),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  // reference model: buffered words, transmitter occupancy, sticky flag
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_cur;
  bit                m_busy;
  bit                m_gap;
  bit                m_ovf;
  bit                prev_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_cur      = '0;
    m_busy     = 1'b0;
    m_gap      = 1'b0;
    m_ovf      = 1'b0;
    prev_start = 1'b0;
  endtask

  task automatic model_step(input bit rv, input logic [DATA_W-1:0] d, input bit td, input bit clr);
    int  pre;
    bit  take;
    pre  = m_q.size();
    take = !m_busy && !m_gap && (pre > 0);
    if (take) m_cur = m_q.pop_front();
    if (rv && pre < DEPTH) begin
      m_q.push_back(d);
      exp_q.push_back(d);
    end
    if (rv && pre == DEPTH) m_ovf = 1'b1;
    else if (clr)           m_ovf = 1'b0;
    if (m_gap)       m_gap = 1'b0;
    else if (m_busy) begin
      if (td) begin
        m_busy = 1'b0;
        m_gap  = 1'b1;
      end
    end else if (take) m_busy = 1'b1;
  endtask

  task automatic compare_all();
    check("fill", 32'(bus.fill_count), 32'(m_q.size()));
    check("rx_enable", 32'(bus.rx_enable), 32'(m_q.size() != DEPTH));
    check("tx_start", 32'(bus.tx_start), 32'(m_busy));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (m_busy) check("tx_data", 32'(bus.tx_data), 32'(m_cur));
    if (bus.tx_start && !prev_start) begin
      if (exp_q.size() == 0) check("sb_extra_word", 32'(exp_q.size()), 32'd1);
      else check("sb_order", 32'(bus.tx_data), 32'(exp_q.pop_front()));
    end
    prev_start = bus.tx_start;
  endtask

  // driver: one clock cycle with the given inputs, called from just after a falling edge
  task automatic cycle(input bit rv, input logic [DATA_W-1:0] d, input bit td, input bit clr);
    bus.rx_valid     = rv;
    bus.rx_data      = d;
    bus.tx_done      = td;
    bus.clr_overflow = clr;
    @(posedge clk);
    model_step(rv, d, td, clr);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, m_busy, 1'b0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((m_q.size() != 0 || m_busy || m_gap) && guard < 2000) begin
      cycle(1'b0, '0, m_busy, 1'b0);
      guard++;
    end
    check("drain_timeout", 32'(guard < 2000), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = '0;
    bus.tx_done      = 1'b0;
    bus.clr_overflow = 1'b0;
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rx_enable", 32'(bus.rx_enable), 32'd1);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_fill", 32'(bus.fill_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // single word latency and handshake
    cycle(1'b1, 8'h41, 1'b0, 1'b0);
    check("t1_fill_k", 32'(bus.fill_count), 32'd1);
    check("t1_start_k", 32'(bus.tx_start), 32'd0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t1_start_k1", 32'(bus.tx_start), 32'd1);
    check("t1_data_k1", 32'(bus.tx_data), 32'h41);
    check("t1_fill_k1", 32'(bus.fill_count), 32'd0);
    idle(2);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("t1_start_m", 32'(bus.tx_start), 32'd0);
    idle(3);

    // burst 0x00..0x0F with transmitter stalled, then one more to reach full
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
    check("t2_fill15", 32'(bus.fill_count), 32'd15);
    cycle(1'b1, 8'h10, 1'b0, 1'b0);
    check("t2_fill16", 32'(bus.fill_count), 32'd16);
    check("t2_rx_enable", 32'(bus.rx_enable), 32'd0);
    check("t2_no_ovf", 32'(bus.overflow), 32'd0);

    // drop while full, clear, clear colliding with drop
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("t3_ovf_set", 32'(bus.overflow), 32'd1);
    check("t3_fill", 32'(bus.fill_count), 32'd16);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t3_ovf_clr", 32'(bus.overflow), 32'd0);
    cycle(1'b1, 8'hBB, 1'b0, 1'b1);
    check("t3_set_wins", 32'(bus.overflow), 32'd1);

    // idle-state pop on the same edge as a push into a full FIFO
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("t5_pre_ovf", 32'(bus.overflow), 32'd0);
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    check("t5_ovf", 32'(bus.overflow), 32'd1);
    check("t5_fill", 32'(bus.fill_count), 32'd15);
    drain();
    cycle(1'b0, '0, 1'b0, 1'b1);

    // 40 words with a continuously responsive transmitter: pointers wrap twice
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'($urandom_range(0, 255)), m_busy, 1'b0);
      cycle(1'b0, '0, m_busy, 1'b0);
      cycle(1'b0, '0, m_busy, 1'b0);
    end
    drain();
    check("t4_no_ovf", 32'(bus.overflow), 32'd0);
    check("t4_all_sent", 32'(exp_q.size()), 32'd0);

    // reset while busy with 5 words buffered
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    check("t6_pre_fill", 32'(bus.fill_count), 32'd5);
    check("t6_pre_busy", 32'(bus.tx_start), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_start", 32'(bus.tx_start), 32'd0);
    check("t6_fill", 32'(bus.fill_count), 32'd0);
    check("t6_rx_enable", 32'(bus.rx_enable), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    check("t6_quiet", 32'(bus.tx_start), 32'd0);

    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 99) < 45), 8'($urandom_range(0, 255)),
            m_busy && ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 19) == 0));
    end
    drain();
    check("rand_all_sent", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
